// File: rtl/pakin_pkg.sv
// Shared sizes, message layout and FSM state types for the packet-in receiver.
package pakin_pkg;
   localparam int PSZ = 4;
   localparam int FSZ = 2;
   localparam int ASZ = 6;
   localparam int DSZ = 4;
   localparam int RSZ = 4;
   localparam int FAW = 2;
   localparam int MSZ = ASZ + DSZ + RSZ;
   localparam int NPK = (MSZ + PSZ - 1) / PSZ;

   typedef struct packed {
      logic [RSZ-1:0] red;
      logic [DSZ-1:0] data;
      logic [ASZ-1:0] addr;
   } msg_t;

   typedef enum logic {ACK_LOW, ACK_HIGH} ack_st_t;
   typedef enum logic {SND_IDLE, SND_REQ} snd_st_t;

   function automatic logic is_last(input logic [FSZ-1:0] idx);
      return int'(idx) == NPK - 1;
   endfunction
endpackage

// File: rtl/pakin_if.sv
// Packet channel (sender -> receiver) and message channel (receiver -> consumer),
// both 4-phase req/ack.
interface pakin_pak_if;
   import pakin_pkg::*;
   logic [PSZ-1:0] pakio;
   logic           req;
   logic           ack;
   modport master (output pakio, output req, input ack);
   modport slave  (input pakio, input req, output ack);
endinterface

interface pakin_msg_if;
   import pakin_pkg::*;
   logic [ASZ-1:0] addr;
   logic [DSZ-1:0] data;
   logic [RSZ-1:0] red;
   logic           req;
   logic           ack;
   modport master (output addr, output data, output red, output req, input ack);
   modport slave  (input addr, input data, input red, input req, output ack);
endinterface

// File: rtl/pakin_fifo.sv
// Message FIFO, 2**FAW deep; head is combinational from the read pointer.
// Callers only push when not full and only pop when not empty.
module pakin_fifo
   import pakin_pkg::*;
(
   input  logic i_clk,
   input  logic reset,
   input  logic push,
   input  msg_t push_dat,
   input  logic pop,
   output logic full,
   output logic empty,
   output msg_t head
);
   localparam int DEPTH = 2 ** FAW;

   msg_t           mem [DEPTH];
   logic [FAW-1:0] wr_ptr;
   logic [FAW-1:0] rd_ptr;
   logic [FAW:0]   count;

   always_ff @(posedge i_clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (push) mem[wr_ptr] <= push_dat;
   end

   assign full  = (count == (FAW+1)'(DEPTH));
   assign empty = (count == '0);
   assign head  = mem[rd_ptr];
endmodule

// File: rtl/pakin.sv
// Reassembles PSZ-bit packets into {red,data,addr} messages, buffers them and
// forwards each on a 4-phase message channel in arrival order.
module pakin
   import pakin_pkg::*;
(
   input  logic        i_clk,
   input  logic        reset,
   output logic        ready,
   pakin_pak_if.slave  rcv0,
   pakin_msg_if.master snd0
);
   logic                   ready_q;
   ack_st_t                ack_st, ack_nxt;
   snd_st_t                snd_st, snd_nxt;
   logic [FSZ-1:0]         idx_q, idx_nxt;
   logic [(NPK-1)*PSZ-1:0] asm_q, asm_nxt;
   logic [NPK*PSZ-1:0]     full_w;
   logic                   push, pop, fifo_full, fifo_empty;
   msg_t                   head;

   always_ff @(posedge i_clk) begin
      if (reset) begin
         ready_q <= 1'b0;
         ack_st  <= ACK_LOW;
         snd_st  <= SND_IDLE;
         idx_q   <= '0;
         asm_q   <= '0;
      end else begin
         ready_q <= 1'b1;
         ack_st  <= ack_nxt;
         snd_st  <= snd_nxt;
         idx_q   <= idx_nxt;
         asm_q   <= asm_nxt;
      end
   end

   // The last packet goes straight into the FIFO word; its pad bits fall off the top.
   assign full_w = {rcv0.pakio, asm_q};

   always_comb begin
      ack_nxt = ack_st;
      idx_nxt = idx_q;
      asm_nxt = asm_q;
      push    = 1'b0;
      if (ready_q) begin
         if (ack_st == ACK_LOW) begin
            if (rcv0.req) begin
               if (!is_last(idx_q)) begin
                  for (int k = 0; k < NPK - 1; k++)
                     if (int'(idx_q) == k) asm_nxt[k*PSZ +: PSZ] = rcv0.pakio;
                  idx_nxt = idx_q + 1'b1;
                  ack_nxt = ACK_HIGH;
               end else if (!fifo_full) begin
                  push    = 1'b1;
                  idx_nxt = '0;
                  ack_nxt = ACK_HIGH;
               end
            end
         end else if (!rcv0.req) begin
            ack_nxt = ACK_LOW;
         end
      end
   end

   always_comb begin
      snd_nxt = snd_st;
      pop     = 1'b0;
      if (ready_q) begin
         if (snd_st == SND_IDLE) begin
            if (!fifo_empty && !snd0.ack) snd_nxt = SND_REQ;
         end else if (snd0.ack) begin
            snd_nxt = SND_IDLE;
            pop     = 1'b1;
         end
      end
   end

   pakin_fifo u_fifo (
      .i_clk    (i_clk),
      .reset    (reset),
      .push     (push),
      .push_dat (msg_t'(MSZ'(full_w))),
      .pop      (pop),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .head     (head)
   );

   // Head cannot change while req is high: only a pop moves the read pointer.
   assign ready     = ready_q;
   assign rcv0.ack  = (ack_st == ACK_HIGH);
   assign snd0.req  = (snd_st == SND_REQ);
   assign snd0.addr = head.addr;
   assign snd0.data = head.data;
   assign snd0.red  = head.red;
endmodule

// File: tb/tb_pakin.sv
// Scoreboard bench for pakin: sender tasks push expected messages, a sink process
// pops and compares them as the DUT delivers.
module tb_pakin;
   import pakin_pkg::*;

   logic i_clk = 1'b0;
   logic reset = 1'b1;
   logic ready;

   always #5 i_clk = ~i_clk;

   pakin_pak_if rcv ();
   pakin_msg_if snd ();

   pakin dut (
      .i_clk (i_clk),
      .reset (reset),
      .ready (ready),
      .rcv0  (rcv),
      .snd0  (snd)
   );

   int   checks = 0;
   int   errors = 0;
   msg_t exp_q[$];
   bit   hold = 1'b0;
   int   ack_dly = 0;
   int   n_rcv = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic msg_t cur_msg();
      return msg_t'({snd.red, snd.data, snd.addr});
   endfunction

   // Consumer: ack held high two cycles so a premature re-request would be seen.
   initial begin
      msg_t e;
      snd.ack = 1'b0;
      forever begin
         @(negedge i_clk);
         if (snd.req && !hold) begin
            chk("sb_has_entry", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               for (int d = 0; d < ack_dly; d++) begin
                  @(negedge i_clk);
                  chk("req_held", snd.req, 1);
                  chk("fields_held", cur_msg(), e);
               end
               chk("msg", cur_msg(), e);
               snd.ack = 1'b1;
               n_rcv++;
               @(negedge i_clk);
               chk("req_drop", snd.req, 0);
               @(negedge i_clk);
               chk("req_rtz", snd.req, 0);
               snd.ack = 1'b0;
            end
         end
      end
   end

   task automatic wait_ack(input logic lvl, input string tag);
      int n = 0;
      do begin
         @(negedge i_clk);
         n++;
      end while (rcv.ack !== lvl && n < 300);
      chk(tag, rcv.ack, lvl);
   endtask

   task automatic send_pkt(input logic [PSZ-1:0] p);
      rcv.pakio = p;
      rcv.req   = 1'b1;
      wait_ack(1'b1, "pkt_ack");
      rcv.req = 1'b0;
      wait_ack(1'b0, "pkt_ack_rtz");
   endtask

   task automatic send_msg(input msg_t m);
      logic [NPK*PSZ-1:0] w;
      exp_q.push_back(m);
      w = (NPK*PSZ)'(m);
      for (int k = 0; k < NPK; k++) send_pkt(w[k*PSZ +: PSZ]);
   endtask

   task automatic drain(input string tag, input int base, input int cnt);
      int n = 0;
      while ((exp_q.size() != 0 || snd.req) && n < 600) begin
         @(negedge i_clk);
         n++;
      end
      repeat (4) @(negedge i_clk);
      chk(tag, exp_q.size(), 0);
      chk({tag, "_count"}, n_rcv - base, cnt);
   endtask

   initial begin
      int base;
      msg_t m;
      rcv.req   = 1'b0;
      rcv.pakio = '0;

      // 1: reset state and ready timing
      reset = 1'b1;
      repeat (3) @(negedge i_clk);
      chk("rst_ready", ready, 0);
      chk("rst_ack", rcv.ack, 0);
      chk("rst_req", snd.req, 0);
      reset = 1'b0;
      @(negedge i_clk);
      chk("ready_up", ready, 1);

      // 2: fixed packets, pad bits ignored, last-packet latency
      base = n_rcv;
      exp_q.push_back(msg_t'({4'h9, 4'h5, 6'h2A}));
      send_pkt(4'hA);
      send_pkt(4'h6);
      send_pkt(4'h5);
      rcv.pakio = 4'hE;
      rcv.req   = 1'b1;
      @(negedge i_clk);
      chk("last_ack_lat", rcv.ack, 1);
      @(negedge i_clk);
      chk("snd_req_lat", snd.req, 1);
      rcv.req = 1'b0;
      wait_ack(1'b0, "last_ack_rtz");
      drain("t2_drain", base, 1);

      // 3: consumer stalls; fifo fills and the 5th last packet is held off
      base = n_rcv;
      hold = 1'b1;
      for (int i = 0; i < 4; i++) send_msg(msg_t'(14'(i * 14'h0A5 + 14'h013)));
      fork
         send_msg(msg_t'(14'h3C1E));
         begin
            repeat (30) @(negedge i_clk);
            chk("full_stall_ack", rcv.ack, 0);
            chk("full_stall_req", rcv.req, 1);
            chk("full_no_delivery", n_rcv - base, 0);
            hold = 1'b0;
         end
      join
      drain("t3_drain", base, 5);

      // 4: back to back with a prompt sink
      base = n_rcv;
      send_msg(msg_t'({4'h1, 4'h2, 6'h03}));
      send_msg(msg_t'({4'hF, 4'h0, 6'h3F}));
      send_msg(msg_t'({4'h6, 4'hB, 6'h11}));
      drain("t4_drain", base, 3);

      // 5: reset drops a partial message
      base = n_rcv;
      send_pkt(4'h7);
      send_pkt(4'h2);
      reset = 1'b1;
      repeat (2) @(negedge i_clk);
      chk("rst2_ready", ready, 0);
      reset = 1'b0;
      @(negedge i_clk);
      m.addr = 6'h15;
      m.data = 4'h3;
      m.red  = 4'h7;
      send_msg(m);
      drain("t5_drain", base, 1);

      // 6: slow consumer, outputs must hold
      base = n_rcv;
      ack_dly = 10;
      send_msg(msg_t'({4'hA, 4'hC, 6'h2D}));
      drain("t6_drain", base, 1);
      ack_dly = 0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
